// File: rtl/prf_free_list.sv
// Circular free list of integer PRF indices shared by rename and the ROB.
// Speculative pops can be rolled back to the committed head in one cycle.
module prf_free_list #(
  parameter int PRF_SIZE    = 64,
  parameter int ARF_SIZE    = 32,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  localparam int DEPTH = PRF_SIZE - ARF_SIZE,
  localparam int IW    = $clog2(PRF_SIZE),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ALLOC_WIDTH-1:0]    alloc_req,
  output logic                      alloc_ok,
  output logic [ALLOC_WIDTH*IW-1:0] alloc_index,
  input  logic [FREE_WIDTH-1:0]     retire_alloc,
  input  logic [FREE_WIDTH-1:0]     free_valid,
  input  logic [FREE_WIDTH*IW-1:0]  free_index,
  input  logic                      recover,
  output logic [PW:0]               free_count,
  output logic                      error
);

  localparam int EW = PW + 3;

  typedef logic [PW:0] ptr_t;

  logic [IW-1:0] mem [DEPTH];

  ptr_t head;
  ptr_t commit_head;
  ptr_t tail;
  ptr_t spec_count;

  ptr_t n_req;
  ptr_t n_pop;
  ptr_t n_push;
  ptr_t n_ret;
  ptr_t aoff;
  ptr_t head_next;
  ptr_t commit_next;
  ptr_t tail_next;

  logic [FREE_WIDTH-1:0] push_ok;
  logic [PW-1:0]         push_slot [FREE_WIDTH];

  logic [EW-1:0] cnt_wide;
  logic [EW-1:0] spec_wide;
  logic          overflow;
  logic          overrun;

  function automatic ptr_t ones_a(input logic [ALLOC_WIDTH-1:0] v);
    ptr_t c;
    c = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) c = c + ptr_t'(v[i]);
    return c;
  endfunction

  function automatic ptr_t ones_f(input logic [FREE_WIDTH-1:0] v);
    ptr_t c;
    c = '0;
    for (int i = 0; i < FREE_WIDTH; i++) c = c + ptr_t'(v[i]);
    return c;
  endfunction

  assign free_count = tail - head;
  assign spec_count = head - commit_head;

  assign n_req    = ones_a(alloc_req);
  assign n_ret    = ones_f(retire_alloc);
  assign alloc_ok = !recover && (n_req <= free_count);
  assign n_pop    = alloc_ok ? n_req : '0;

  // Every lane reads the entry its rank among requesting lanes selects
  always_comb begin
    aoff        = '0;
    alloc_index = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_index[i*IW +: IW] = mem[head[PW-1:0] + aoff[PW-1:0]];
      aoff = aoff + ptr_t'(alloc_req[i]);
    end
  end

  // Index 0 is never allocatable, so a lane freeing it is dropped
  always_comb begin
    n_push = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      push_ok[i]   = free_valid[i] && (free_index[i*IW +: IW] != '0);
      push_slot[i] = tail[PW-1:0] + n_push[PW-1:0];
      n_push       = n_push + ptr_t'(push_ok[i]);
    end
  end

  assign commit_next = commit_head + n_ret;
  assign tail_next   = tail + n_push;
  assign head_next   = recover ? commit_next : head + n_pop;

  always_comb begin
    cnt_wide  = EW'(free_count) + EW'(n_push) - EW'(n_pop);
    spec_wide = '0;
    if (recover) begin
      cnt_wide = cnt_wide + EW'(spec_count) - EW'(n_ret);
    end else begin
      spec_wide = EW'(spec_count) + EW'(n_pop) - EW'(n_ret);
    end
  end

  assign overflow = !cnt_wide[EW-1] && (cnt_wide[EW-2:0] > (EW-1)'(DEPTH));
  assign overrun  = spec_wide[EW-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(DEPTH);
      error       <= 1'b0;
    end else begin
      head        <= head_next;
      commit_head <= commit_next;
      tail        <= tail_next;
      if (overflow || overrun) error <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IW-1:0] q;
    always_ff @(posedge clock) begin
      if (reset) begin
        q <= IW'(ARF_SIZE + g);
      end else begin
        for (int i = 0; i < FREE_WIDTH; i++) begin
          if (push_ok[i] && (push_slot[i] == PW'(g))) begin
            q <= free_index[i*IW +: IW];
          end
        end
      end
    end
    assign mem[g] = q;
  end

endmodule
